switch_cfg_ctrl: RTL and testbench

// Configuration sequencer for a switch's register bank: owns route_lut and dateline storage.

---
 rtl/switch_cfg_ctrl.sv | 163 ++++++++++++++++
 tb/tb_switch_cfg_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/switch_cfg_ctrl.sv
// Configuration sequencer for a switch register bank: decodes config packets from a
// valid/ready word stream and commits route LUT entries, the dateline mask and table clears.
module switch_cfg_ctrl #(
  parameter int unsigned NUM_OUTPORTS = 4,
  parameter int unsigned TOTAL_NODES  = 16,
  parameter int unsigned TABLE_SIZE   = 8,
  localparam int unsigned PORT_W  = (NUM_OUTPORTS > 1) ? $clog2(NUM_OUTPORTS) : 1,
  localparam int unsigned NODE_W  = (TOTAL_NODES > 1) ? $clog2(TOTAL_NODES) : 1,
  localparam int unsigned IDX_W   = (TABLE_SIZE > 1) ? $clog2(TABLE_SIZE) : 1,
  localparam int unsigned ENTRY_W = 2 * NODE_W + PORT_W + 1,
  localparam int unsigned LUT_W   = TABLE_SIZE * ENTRY_W
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [31:0]             cfg_data,
  input  logic                    cfg_last,
  input  logic                    err_clr,
  output logic [LUT_W-1:0]        route_lut,
  output logic [NUM_OUTPORTS-1:0] dateline,
  output logic                    lut_upd,
  output logic                    busy,
  output logic                    err
);

  localparam logic [3:0] OP_WR_LUT = 4'h1;
  localparam logic [3:0] OP_WR_DL  = 4'h2;
  localparam logic [3:0] OP_CLR    = 4'h3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LUT_DATA,
    S_DL_DATA,
    S_CLEAR,
    S_DRAIN
  } state_e;

  state_e state_q, state_d;

  logic [ENTRY_W-1:0] lut_q [TABLE_SIZE];
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   cnt_q;
  logic               pend_q;

  logic       xfer;
  logic [3:0] opcode;
  logic [7:0] hdr_idx;
  logic       hdr_idx_ok;
  logic       cnt_last;
  logic       lut_wr, dl_wr, clr_wr, idx_ld, clr_start, err_set;
  logic       cfg_data_unused;

  assign cfg_ready  = (state_q != S_CLEAR);
  assign busy       = (state_q != S_IDLE);
  assign xfer       = cfg_valid && cfg_ready;
  assign opcode     = cfg_data[31:28];
  assign hdr_idx    = cfg_data[7:0];
  assign hdr_idx_ok = (32'(hdr_idx) < TABLE_SIZE);
  assign cnt_last   = (32'(cnt_q) == TABLE_SIZE - 1);
  // Header bits [27:8] and data bits above the entry/mask width carry no meaning.
  assign cfg_data_unused = &{1'b0, cfg_data};

  for (genvar g = 0; g < TABLE_SIZE; g++) begin : g_flat
    assign route_lut[g*ENTRY_W +: ENTRY_W] = lut_q[g];
  end

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and datapath control decode
  always_comb begin
    state_d   = state_q;
    lut_wr    = 1'b0;
    dl_wr     = 1'b0;
    clr_wr    = 1'b0;
    idx_ld    = 1'b0;
    clr_start = 1'b0;
    err_set   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (xfer) begin
          unique case (opcode)
            OP_WR_LUT: begin
              if (!hdr_idx_ok) begin
                err_set = 1'b1;
                state_d = cfg_last ? S_IDLE : S_DRAIN;
              end else if (cfg_last) begin
                err_set = 1'b1;
              end else begin
                idx_ld  = 1'b1;
                state_d = S_LUT_DATA;
              end
            end
            OP_WR_DL: begin
              if (cfg_last) err_set = 1'b1;
              else          state_d = S_DL_DATA;
            end
            OP_CLR: begin
              clr_start = 1'b1;
              state_d   = S_CLEAR;
            end
            default: begin
              err_set = 1'b1;
              state_d = cfg_last ? S_IDLE : S_DRAIN;
            end
          endcase
        end
      end
      S_LUT_DATA, S_DL_DATA: begin
        if (xfer) begin
          lut_wr  = (state_q == S_LUT_DATA);
          dl_wr   = (state_q == S_DL_DATA);
          err_set = !cfg_last;
          state_d = cfg_last ? S_IDLE : S_DRAIN;
        end
      end
      S_CLEAR: begin
        clr_wr = 1'b1;
        if (cnt_last) begin
          err_set = pend_q;
          state_d = pend_q ? S_DRAIN : S_IDLE;
        end
      end
      S_DRAIN: begin
        if (xfer && cfg_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register bank, clear sequencing and status flags
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < TABLE_SIZE; i++) lut_q[i] <= '0;
      dateline <= '0;
      lut_upd  <= 1'b0;
      err      <= 1'b0;
      idx_q    <= '0;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
    end else begin
      lut_upd <= lut_wr || dl_wr || (clr_wr && cnt_last);
      if (idx_ld) idx_q <= hdr_idx[IDX_W-1:0];
      if (clr_start) begin
        cnt_q  <= '0;
        pend_q <= !cfg_last;
      end else if (clr_wr) begin
        cnt_q <= cnt_q + IDX_W'(1);
      end
      if (lut_wr) lut_q[idx_q] <= cfg_data[ENTRY_W-1:0];
      if (clr_wr) lut_q[cnt_q] <= '0;
      if (dl_wr)  dateline <= cfg_data[NUM_OUTPORTS-1:0];
      // A new error in the same cycle as err_clr keeps the flag set.
      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_switch_cfg_ctrl.sv
// Directed bench for switch_cfg_ctrl: stimulus pushes expected bank snapshots for every
// lut_upd pulse into a scoreboard; a monitor pops and compares when the pulse appears.
module tb_switch_cfg_ctrl;

  localparam int unsigned ENTRY_W = 11;
  localparam int unsigned LUT_W   = 88;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [31:0]      cfg_data;
  logic             cfg_last;
  logic             err_clr;
  logic [LUT_W-1:0] route_lut;
  logic [3:0]       dateline;
  logic             lut_upd;
  logic             busy;
  logic             err;

  switch_cfg_ctrl #(.NUM_OUTPORTS(4), .TOTAL_NODES(16), .TABLE_SIZE(8)) dut (
    .clk(clk), .n_rst(n_rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .cfg_last(cfg_last), .err_clr(err_clr),
    .route_lut(route_lut), .dateline(dateline), .lut_upd(lut_upd),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LUT_W-1:0] lut;
    logic [3:0]       dl;
    logic             err;
    string            tag;
  } exp_t;

  exp_t         sb[$];
  logic [10:0]  exp_lut [8];
  logic [3:0]   exp_dl;
  logic         exp_err;
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [10:0]  fill_v [8] = '{11'h051, 11'h144, 11'h237, 11'h32A,
                               11'h41D, 11'h510, 11'h603, 11'h7F6};

  function automatic logic [LUT_W-1:0] flat();
    logic [LUT_W-1:0] r;
    for (int i = 0; i < 8; i++) r[i*ENTRY_W +: ENTRY_W] = exp_lut[i];
    return r;
  endfunction

  task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input string tag);
    exp_t e;
    e.lut = flat();
    e.dl  = exp_dl;
    e.err = exp_err;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [31:0] d, input logic l);
    int w = 0;
    cfg_valid = 1'b1;
    cfg_data  = d;
    cfg_last  = l;
    while (!cfg_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (!cfg_ready) begin
      n_bad++;
      $display("FAIL send_accept: cfg_ready held 0 for %0d cycles, expected 1", w);
    end else begin
      @(posedge clk);
    end
    @(negedge clk);
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    cfg_data  = '0;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_err = 1'b0;
    cmp("err_clr", 128'(err), 128'(exp_err));
  endtask

  // Monitor: every lut_upd pulse must match the oldest expected snapshot.
  always @(negedge clk) begin
    if (n_rst && lut_upd) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_lut_upd: got pulse, expected none");
      end else begin
        exp_t e;
        e = sb.pop_front();
        cmp({e.tag, "_lut"}, 128'(route_lut), 128'(e.lut));
        cmp({e.tag, "_dl"},  128'(dateline),  128'(e.dl));
        cmp({e.tag, "_err"}, 128'(err),       128'(e.err));
      end
    end
  end

  initial begin
    int lo;
    n_rst = 1'b0; cfg_valid = 1'b0; cfg_data = '0; cfg_last = 1'b0; err_clr = 1'b0;
    for (int i = 0; i < 8; i++) exp_lut[i] = '0;
    exp_dl = '0;
    exp_err = 1'b0;
    repeat (2) @(negedge clk);
    cmp("rst_lut",   128'(route_lut), 128'(0));
    cmp("rst_dl",    128'(dateline),  128'(0));
    cmp("rst_err",   128'(err),       128'(0));
    cmp("rst_upd",   128'(lut_upd),   128'(0));
    cmp("rst_busy",  128'(busy),      128'(0));
    cmp("rst_ready", 128'(cfg_ready), 128'(1));
    n_rst = 1'b1;
    @(negedge clk);

    // Single LUT write
    send(32'h1000_0005, 1'b0);
    cmp("wr_lut_busy", 128'(busy), 128'(1));
    exp_lut[5] = 11'h637;
    push("wr_lut5");
    send(32'h0000_0637, 1'b1);
    cmp("wr_lut_err", 128'(err), 128'(0));

    // Dateline write with a 3-cycle valid gap
    send(32'h2000_0000, 1'b0);
    repeat (3) @(negedge clk);
    cmp("wr_dl_gap_busy", 128'(busy), 128'(1));
    exp_dl = 4'b1010;
    push("wr_dl");
    send(32'h0000_000A, 1'b1);

    // Fill all entries, with junk in ignored header and data bits
    for (int i = 0; i < 8; i++) begin
      send(32'h1ABC_DE00 | 32'(i), 1'b0);
      exp_lut[i] = fill_v[i];
      push("fill");
      send(32'hABCD_F800 | 32'(fill_v[i]), 1'b1);
    end

    // Table clear: ready low for 8 cycles, dateline kept
    for (int i = 0; i < 8; i++) exp_lut[i] = '0;
    push("clr");
    send(32'h3000_0000, 1'b1);
    lo = 0;
    while (!cfg_ready && lo < 30) begin
      lo++;
      @(negedge clk);
    end
    cmp("clr_ready_low_cycles", 128'(lo), 128'(8));
    cmp("clr_busy_after", 128'(busy), 128'(0));

    // Out-of-range index: drained, LUT untouched (idx 9 would alias to 1)
    send(32'h1000_0001, 1'b0);
    exp_lut[1] = 11'h3C5;
    push("wr_lut1");
    send(32'h0000_03C5, 1'b1);
    send(32'h1000_0009, 1'b0);
    exp_err = 1'b1;
    cmp("bad_idx_err", 128'(err), 128'(1));
    cmp("bad_idx_drain_busy", 128'(busy), 128'(1));
    send(32'h0000_0555, 1'b1);
    cmp("bad_idx_lut", 128'(route_lut), 128'(flat()));
    cmp("bad_idx_idle", 128'(busy), 128'(0));
    pulse_err_clr();

    // Unknown opcode, three-word packet
    send(32'h7000_0000, 1'b0);
    cmp("bad_op_err", 128'(err), 128'(1));
    send(32'h1234_5678, 1'b0);
    cmp("bad_op_busy", 128'(busy), 128'(1));
    send(32'h0000_0009, 1'b1);
    cmp("bad_op_idle", 128'(busy), 128'(0));
    cmp("bad_op_lut", 128'(route_lut), 128'(flat()));
    pulse_err_clr();

    // Truncated WR_LUT header
    send(32'h1000_0004, 1'b1);
    cmp("trunc_err", 128'(err), 128'(1));
    cmp("trunc_idle", 128'(busy), 128'(0));
    pulse_err_clr();

    // Missing last on data word: entry committed, two words drained
    send(32'h1000_0002, 1'b0);
    exp_lut[2] = 11'h2AB;
    exp_err = 1'b1;
    push("nolast");
    send(32'h0000_02AB, 1'b0);
    cmp("nolast_busy0", 128'(busy), 128'(1));
    send(32'hDEAD_BEEF, 1'b0);
    cmp("nolast_busy1", 128'(busy), 128'(1));
    send(32'h0000_0000, 1'b1);
    cmp("nolast_idle", 128'(busy), 128'(0));
    cmp("nolast_err", 128'(err), 128'(1));
    cmp("nolast_lut", 128'(route_lut), 128'(flat()));

    // Reset at clear count 3 aborts everything
    send(32'h3000_0000, 1'b1);
    repeat (3) @(negedge clk);
    cmp("midclr_busy", 128'(busy), 128'(1));
    n_rst = 1'b0;
    #1;
    cmp("midclr_rst_lut",   128'(route_lut), 128'(0));
    cmp("midclr_rst_dl",    128'(dateline),  128'(0));
    cmp("midclr_rst_err",   128'(err),       128'(0));
    cmp("midclr_rst_upd",   128'(lut_upd),   128'(0));
    cmp("midclr_rst_busy",  128'(busy),      128'(0));
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    cmp("midclr_ready", 128'(cfg_ready), 128'(1));
    cmp("midclr_idle",  128'(busy),      128'(0));
    repeat (12) @(negedge clk);
    cmp("midclr_no_resume_lut", 128'(route_lut), 128'(0));
    cmp("scoreboard_empty", 128'(sb.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
